// File: rtl/block_check_sched.sv
// Time-shares one begin/end checker between two character sources: collects a
// sentence, replays it as a gap-free burst, and reports the verdict with the source ID.
module block_check_sched #(
    parameter int MAX_LEN = 16,
    parameter int CNT_W   = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0_valid,
    input  logic [7:0] req0_char,
    input  logic       req0_last,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_char,
    input  logic       req1_last,
    output logic       req1_ready,
    output logic [7:0] chk_in,
    output logic       chk_clear,
    input  logic       chk_result,
    output logic       res_valid,
    output logic       res_id,
    output logic       res_value,
    output logic       res_ovf,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_BURST,
        S_HOLD,
        S_REPORT
    } state_e;

    localparam int               AW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(MAX_LEN);
    localparam logic [7:0]       SPACE   = 8'h20;

    state_e           state_q, state_d;
    logic             grant_q, grant_d;
    logic             last_q, last_d;      // source served most recently
    logic [CNT_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic             ovf_q, ovf_d;
    logic [1:0]       ready_q, ready_d;
    logic [7:0]       chk_in_q, chk_in_d;
    logic             chk_clear_q, chk_clear_d;
    logic             res_valid_q, res_valid_d;
    logic             res_id_q, res_id_d;
    logic             res_value_q, res_value_d;
    logic             res_ovf_q, res_ovf_d;
    logic             busy_q, busy_d;

    logic [7:0]       buf_mem [MAX_LEN];

    logic             in_valid;
    logic             in_last;
    logic [7:0]       in_char;
    logic             accept;
    logic             store;

    always_comb begin
        in_valid = grant_q ? req1_valid : req0_valid;
        in_char  = grant_q ? req1_char  : req0_char;
        in_last  = grant_q ? req1_last  : req0_last;
        accept   = in_valid && ready_q[grant_q];
        store    = accept && (len_q < LEN_MAX);
    end

    // NOTE: every variable gets its default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        len_d       = len_q;
        idx_d       = idx_q;
        ovf_d       = ovf_q;
        ready_d     = ready_q;
        chk_in_d    = chk_in_q;
        chk_clear_d = chk_clear_q;
        res_valid_d = 1'b0;
        res_id_d    = res_id_q;
        res_value_d = res_value_q;
        res_ovf_d   = res_ovf_q;

        case (state_q)
            S_IDLE: begin
                chk_clear_d = 1'b1;
                chk_in_d    = SPACE;
                if (req0_valid || req1_valid) begin
                    grant_d = (req0_valid && req1_valid) ? ~last_q : req1_valid;
                    ready_d = grant_d ? 2'b10 : 2'b01;
                    len_d   = '0;
                    idx_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (accept) begin
                    if (store) len_d = len_q + CNT_W'(1);
                    else       ovf_d = 1'b1;
                    if (in_last) begin
                        // A one-char sentence is still being written, so bypass the buffer.
                        ready_d     = 2'b00;
                        chk_clear_d = 1'b0;
                        chk_in_d    = (len_q == '0) ? in_char : buf_mem[0];
                        idx_d       = CNT_W'(1);
                        state_d     = S_BURST;
                    end
                end
            end
            S_BURST: begin
                if (idx_q < len_q) begin
                    chk_in_d = buf_mem[idx_q[AW-1:0]];
                    idx_d    = idx_q + CNT_W'(1);
                end else begin
                    chk_in_d = SPACE;
                    state_d  = S_HOLD;
                end
            end
            S_HOLD: begin
                res_valid_d = 1'b1;
                res_id_d    = grant_q;
                res_value_d = ovf_q ? 1'b0 : chk_result;
                res_ovf_d   = ovf_q;
                chk_clear_d = 1'b1;
                chk_in_d    = SPACE;
                state_d     = S_REPORT;
            end
            S_REPORT: begin
                last_d  = grant_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            grant_q     <= 1'b0;
            last_q      <= 1'b1;
            len_q       <= '0;
            idx_q       <= '0;
            ovf_q       <= 1'b0;
            ready_q     <= 2'b00;
            chk_in_q    <= SPACE;
            chk_clear_q <= 1'b1;
            res_valid_q <= 1'b0;
            res_id_q    <= 1'b0;
            res_value_q <= 1'b0;
            res_ovf_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            ovf_q       <= ovf_d;
            ready_q     <= ready_d;
            chk_in_q    <= chk_in_d;
            chk_clear_q <= chk_clear_d;
            res_valid_q <= res_valid_d;
            res_id_q    <= res_id_d;
            res_value_q <= res_value_d;
            res_ovf_q   <= res_ovf_d;
            busy_q      <= busy_d;
        end
    end

    // NOTE: the sentence buffer has no reset; entries are only read after being written in COLLECT.
    always_ff @(posedge clk) begin
        if (state_q == S_COLLECT && store) begin
            buf_mem[len_q[AW-1:0]] <= in_char;
        end
    end

    assign req0_ready = ready_q[0];
    assign req1_ready = ready_q[1];
    assign chk_in     = chk_in_q;
    assign chk_clear  = chk_clear_q;
    assign res_valid  = res_valid_q;
    assign res_id     = res_id_q;
    assign res_value  = res_value_q;
    assign res_ovf    = res_ovf_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_block_check_sched.sv
// Bench for block_check_sched: begin/end checker model, two source drivers, and a
// sentence-level scoreboard compared against the DUT on every cycle.
module tb_block_check_sched;

    localparam int MAX_LEN = 16;
    localparam int BUDGET  = 2000;

    typedef logic [7:0] bq_t[$];
    typedef enum {M_IDLE, M_COLL, M_OUT} mmode_e;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0_valid, req0_last, req0_ready;
    logic [7:0] req0_char;
    logic       req1_valid, req1_last, req1_ready;
    logic [7:0] req1_char;
    logic [7:0] chk_in;
    logic       chk_clear, chk_result;
    logic       res_valid, res_id, res_value, res_ovf, busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    block_check_sched #(.MAX_LEN(MAX_LEN), .CNT_W(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_char  (req0_char),
        .req0_last  (req0_last),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_char  (req1_char),
        .req1_last  (req1_last),
        .req1_ready (req1_ready),
        .chk_in     (chk_in),
        .chk_clear  (chk_clear),
        .chk_result (chk_result),
        .res_valid  (res_valid),
        .res_id     (res_id),
        .res_value  (res_value),
        .res_ovf    (res_ovf),
        .busy       (busy)
    );

    // Checker stand-in: keyword recognised on its final char, async clear, registered verdict.
    logic [39:0] ck_hist;
    logic [39:0] hist_n;
    int          ck_depth;
    logic        ck_err, ck_seen;
    assign hist_n = {ck_hist[31:0], chk_in};

    always @(posedge clk or posedge chk_clear) begin
        if (chk_clear) begin
            ck_hist    <= '0;
            ck_depth   <= 0;
            ck_err     <= 1'b0;
            ck_seen    <= 1'b0;
            chk_result <= 1'b0;
        end else begin
            ck_hist <= hist_n;
            if (hist_n == "begin") begin
                ck_depth   <= ck_depth + 1;
                chk_result <= 1'b0;
            end else if (hist_n[23:0] == "end") begin
                if (ck_depth == 0) begin
                    ck_err     <= 1'b1;
                    chk_result <= 1'b0;
                end else begin
                    ck_depth   <= ck_depth - 1;
                    ck_seen    <= 1'b1;
                    chk_result <= !ck_err && (ck_depth == 1);
                end
            end else begin
                chk_result <= !ck_err && (ck_depth == 0) && ck_seen;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bq_t str2q(input string s);
        bq_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        return q;
    endfunction

    // Reference verdict: split on spaces, nest begin/end words, need at least one matched pair.
    function automatic bit ref_verdict(input bq_t s);
        int          depth = 0;
        bit          bad   = 0;
        bit          seen  = 0;
        logic [39:0] wb    = '0;
        int          wl    = 0;
        for (int i = 0; i <= s.size(); i++) begin
            if (i == s.size() || s[i] == 8'h20) begin
                if (wl == 5 && wb == "begin") depth++;
                else if (wl == 3 && wb[23:0] == "end") begin
                    if (depth == 0) bad = 1;
                    else begin depth--; seen = 1; end
                end
                wl = 0;
                wb = '0;
            end else begin
                wb = {wb[31:0], s[i]};
                wl++;
            end
        end
        return !bad && depth == 0 && seen;
    endfunction

    function automatic bq_t gen_sentence();
        bq_t   q;
        string w;
        int    n;
        case ($urandom_range(0, 3))
            0: q = str2q("begin end");
            1: q = str2q("begin begin end end");
            default: begin
                n = $urandom_range(1, 6);
                for (int i = 0; i < n; i++) begin
                    case ($urandom_range(0, 5))
                        0, 1:    w = "begin";
                        2, 3:    w = "end";
                        4:       w = "x";
                        default: w = "be";
                    endcase
                    if (i > 0) q.push_back(8'h20);
                    for (int j = 0; j < w.len(); j++) q.push_back(w[j]);
                end
            end
        endcase
        return q;
    endfunction

    // Scoreboard state, advanced once per cycle by the compare process
    mmode_e m_mode = M_IDLE;
    bit     m_g, m_last;
    int     m_e, m_blen;
    int     cyc = 0;
    bq_t    m_bytes;
    bit     e_id, e_val, e_ovf;
    bit     armed = 0;
    int     n_rep[2];
    int     n_sent[2];
    int     rep_ids[$];

    task automatic reset_model();
        m_mode = M_IDLE;
        m_last = 1'b1;
        e_id   = 1'b0;
        e_val  = 1'b0;
        e_ovf  = 1'b0;
        m_bytes.delete();
    endtask

    task automatic monitor_step();
        logic [1:0] e_ready;
        logic       e_clear, e_rv, e_busy;
        logic [7:0] e_in;
        logic [7:0] c;
        int         k;
        k       = cyc - m_e;
        e_ready = 2'b00;
        e_clear = 1'b1;
        e_in    = 8'h20;
        e_rv    = 1'b0;
        e_busy  = (m_mode != M_IDLE);
        if (m_mode == M_COLL) e_ready = m_g ? 2'b10 : 2'b01;
        if (m_mode == M_OUT) begin
            if (k >= 1 && k <= m_blen) begin
                e_clear = 1'b0;
                e_in    = m_bytes[k-1];
            end else if (k == m_blen + 1) begin
                e_clear = 1'b0;
            end else if (k == m_blen + 2) begin
                e_rv  = 1'b1;
                e_id  = m_g;
                e_ovf = (m_bytes.size() > MAX_LEN);
                e_val = !e_ovf && ref_verdict(m_bytes);
            end
        end
        if (armed) begin
            check("ready",     {30'd0, req1_ready, req0_ready}, {30'd0, e_ready});
            check("chk_clear", chk_clear, e_clear);
            check("chk_in",    chk_in,    e_in);
            check("res_valid", res_valid, e_rv);
            check("busy",      busy,      e_busy);
            check("res_id",    res_id,    e_id);
            check("res_value", res_value, e_val);
            check("res_ovf",   res_ovf,   e_ovf);
            if (e_rv) begin
                n_rep[m_g]++;
                rep_ids.push_back(int'(m_g));
            end
        end
        if (!reset) begin
            reset_model();
            armed = 1;
        end else begin
            case (m_mode)
                M_IDLE: if (req0_valid || req1_valid) begin
                    m_g    = (req0_valid && req1_valid) ? !m_last : req1_valid;
                    m_mode = M_COLL;
                    m_bytes.delete();
                end
                M_COLL: if (m_g ? req1_valid : req0_valid) begin
                    c = m_g ? req1_char : req0_char;
                    m_bytes.push_back(c);
                    if (m_g ? req1_last : req0_last) begin
                        m_e    = cyc;
                        m_blen = (m_bytes.size() > MAX_LEN) ? MAX_LEN : m_bytes.size();
                        m_mode = M_OUT;
                    end
                end
                default: if (k == m_blen + 2) begin
                    m_mode = M_IDLE;
                    m_last = m_g;
                end
            endcase
        end
        cyc++;
    endtask

    always begin
        @(negedge clk);
        #2;
        monitor_step();
    end

    task automatic drive(input bit src, input bit v, input logic [7:0] c, input bit l);
        if (src) begin req1_valid = v; req1_char = c; req1_last = l; end
        else     begin req0_valid = v; req0_char = c; req0_last = l; end
    endtask

    function automatic bit rdy(input bit src);
        return src ? req1_ready : req0_ready;
    endfunction

    // Called just after a negedge; returns at the negedge following the last handshake.
    task automatic send(input bit src, input bq_t s, input int stall_pct,
                        input int stall_at, input int stall_len);
        int k;
        for (int i = 0; i < s.size(); i++) begin
            if (i == stall_at) begin
                drive(src, 1'b0, 8'h00, 1'b0);
                repeat (stall_len) @(negedge clk);
            end else if (int'($urandom_range(0, 99)) < stall_pct) begin
                drive(src, 1'b0, 8'h00, 1'b0);
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
            drive(src, 1'b1, s[i], i == s.size() - 1);
            k = 0;
            while (!rdy(src) && k < BUDGET) begin
                @(negedge clk);
                k++;
            end
            if (k >= BUDGET) begin
                n_tests++;
                n_fail++;
                $display("FAIL handshake src%0d: no ready within %0d cycles", src, BUDGET);
            end
            @(negedge clk);
        end
        drive(src, 1'b0, 8'h00, 1'b0);
        n_sent[src]++;
    endtask

    task automatic wait_result(output bit id, output bit val, output bit ovf, output int k);
        k = 0;
        while (!res_valid && k < 400) begin
            @(negedge clk);
            k++;
        end
        if (!res_valid) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_result: no res_valid within %0d cycles", k);
        end
        id  = res_id;
        val = res_value;
        ovf = res_ovf;
        @(negedge clk);
    endtask

    task automatic drain();
        int idle_cnt = 0;
        int t = 0;
        while (idle_cnt < 4 && t < 1000) begin
            @(negedge clk);
            t++;
            if (!busy && m_mode == M_IDLE) idle_cnt++;
            else idle_cnt = 0;
        end
        if (t >= 1000) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: design still busy after %0d cycles", t);
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit  id, val, ovf;
        int  k, base;
        bq_t s;

        reset = 1'b0;
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        drive(1'b1, 1'b0, 8'h00, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        check("rst chk_in", chk_in, 8'h20);
        check("rst chk_clear", chk_clear, 1);
        check("rst ready", {req1_ready, req0_ready}, 0);
        check("rst busy", busy, 0);
        check("rst res_valid", res_valid, 0);

        check("model begin_end", ref_verdict(str2q("begin end")), 1);
        check("model begin", ref_verdict(str2q("begin")), 0);
        check("model end", ref_verdict(str2q("end")), 0);
        check("model nested", ref_verdict(str2q("begin begin end end")), 1);
        check("model end_begin", ref_verdict(str2q("end begin")), 0);

        // Single sentence from source 0
        send(1'b0, str2q("begin end"), 0, -1, 0);
        wait_result(id, val, ovf, k);
        check("t1 latency", k + 1, 11);
        check("t1 id", id, 0);
        check("t1 value", val, 1);
        check("t1 ovf", ovf, 0);

        // Two sentences from source 1
        send(1'b1, str2q("begin"), 0, -1, 0);
        wait_result(id, val, ovf, k);
        check("t2a id", id, 1);
        check("t2a value", val, 0);
        send(1'b1, str2q("end"), 0, -1, 0);
        wait_result(id, val, ovf, k);
        check("t2b id", id, 1);
        check("t2b value", val, 0);
        check("t2b latency", k + 1, 5);

        // Both sources contending: strict alternation starting with source 0
        base = rep_ids.size();
        fork
            begin
                send(1'b0, str2q("begin end"), 0, -1, 0);
                send(1'b0, str2q("begin end"), 0, -1, 0);
            end
            begin
                send(1'b1, str2q("begin end"), 0, -1, 0);
                send(1'b1, str2q("begin end"), 0, -1, 0);
            end
        join
        drain();
        check("t3 count", rep_ids.size() - base, 4);
        if (rep_ids.size() - base == 4) begin
            for (int i = 0; i < 4; i++) check("t3 order", rep_ids[base+i], i % 2);
        end

        // Overflow: 20 chars into a 16-entry buffer
        s = str2q("begin end");
        repeat (11) s.push_back(8'h20);
        send(1'b0, s, 0, -1, 0);
        wait_result(id, val, ovf, k);
        check("t4 latency", k + 1, MAX_LEN + 2);
        check("t4 id", id, 0);
        check("t4 value", val, 0);
        check("t4 ovf", ovf, 1);

        // Source stall mid-sentence
        send(1'b0, str2q("begin end"), 0, 3, 5);
        wait_result(id, val, ovf, k);
        check("t5 latency", k + 1, 11);
        check("t5 value", val, 1);
        check("t5 ovf", ovf, 0);

        // Reset during the 4th burst cycle discards the sentence
        base = rep_ids.size();
        send(1'b0, str2q("begin end"), 0, -1, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        n_sent[0]--;
        check("t6 busy", busy, 0);
        check("t6 chk_clear", chk_clear, 1);
        check("t6 res_valid", res_valid, 0);
        repeat (15) @(negedge clk);
        check("t6 no report", rep_ids.size() - base, 0);
        fork
            send(1'b0, str2q("begin end"), 0, -1, 0);
            send(1'b1, str2q("begin end"), 0, -1, 0);
        join
        drain();
        check("t6 count", rep_ids.size() - base, 2);
        if (rep_ids.size() - base == 2) begin
            check("t6 first id", rep_ids[base], 0);
            check("t6 second id", rep_ids[base+1], 1);
        end

        // Randomised traffic from both sources
        fork
            for (int i = 0; i < 30; i++) begin
                send(1'b0, gen_sentence(), 15, -1, 0);
                repeat ($urandom_range(0, 4)) @(negedge clk);
            end
            for (int i = 0; i < 30; i++) begin
                send(1'b1, gen_sentence(), 15, -1, 0);
                repeat ($urandom_range(0, 4)) @(negedge clk);
            end
        join
        drain();

        check("reports src0", n_rep[0], n_sent[0]);
        check("reports src1", n_rep[1], n_sent[1]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/block_check_sched.md
Name: block_check_sched

Overview:
- Schedules one shared keyword-matching checker (begin/end nesting FSM, 8-bit ASCII in, 1-bit result, active-high async reset) between two character sources.
- Collects one whole sentence from a granted source into an internal buffer.
- Replays the buffer to the checker in a gap-free burst, samples the verdict and reports it tagged with the source ID.
- Holds the checker in clear whenever it is not streaming. Round-robin arbitration between sentences.

Parameters:
- MAX_LEN, 16, buffer depth in characters; longer sentences are truncated and flagged.
- CNT_W, 5, width of the length counter; must satisfy MAX_LEN <= 2^CNT_W - 1.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-low reset (sampled on clk rising edge, asserted when 0)
- req0_valid  input  1  source 0 character valid
- req0_char  input  8  source 0 ASCII character
- req0_last  input  1  marks final character of the sentence (the sentence is at least 1 character)
- req0_ready  output  1  source 0 character accepted when valid&ready
- req1_valid, req1_char, req1_last, req1_ready  same widths and meaning for source 1
- chk_in  output  8  character to checker; registered
- chk_clear  output  1  active-high clear to checker; registered
- chk_result  input  1  checker verdict, registered inside the checker
- res_valid  output  1  one-cycle pulse: verdict available
- res_id  output  1  source that produced the sentence
- res_value  output  1  checker verdict (forced 0 on overflow)
- res_ovf  output  1  sentence exceeded MAX_LEN
- busy  output  1  high in any state other than IDLE

Behaviour:
- States: IDLE, COLLECT, BURST, HOLD, REPORT. All outputs are registered.
- Reset (reset==0 at an edge):
  - State goes to IDLE; rr pointer prefers source 0; length and index counters clear; ovf flag clears.
  - Outputs: req*_ready=0, chk_in=8'h20, chk_clear=1, res_valid=0, res_id=0, res_value=0, res_ovf=0, busy=0.
  - Reset takes effect from any state, including mid-BURST. The partial sentence is discarded and no result is produced.
- IDLE:
  - chk_clear=1.
  - If exactly one reqN_valid is high, grant N.
  - If both are high, grant the source not served last; after reset, source 0 wins.
  - Next state is COLLECT. The grant is latched and the length counter is cleared.
- COLLECT:
  - Only the granted reqN_ready=1; the other source's ready stays 0.
  - On each valid&ready: if len<MAX_LEN, store the char at buf[len] and increment len; otherwise drop the char and set ovf.
  - A source stall (valid=0) just waits; the checker stays cleared.
  - On an accepted char with last=1: ready drops next cycle and the state goes to BURST.
- BURST:
  - Lasts exactly len cycles with chk_clear=0 and chk_in=buf[0..len-1], one per cycle, with no gaps.
  - chk_clear deasserts in the same cycle chk_in=buf[0].
- HOLD:
  - One cycle, chk_clear=0, chk_in=8'h20.
  - Controller registers chk_result at the end of this cycle, i.e. the value after the checker consumed buf[len-1].
- REPORT:
  - One cycle: res_valid=1, res_id=grant, res_value = ovf ? 0 : captured result, res_ovf=ovf.
  - chk_clear=1 and chk_in=8'h20.
  - rr pointer updates to the granted source. Next state is IDLE.
- Latency: if the last char is accepted at edge E, BURST spans cycles E+1..E+len, HOLD is E+len+1, and res_valid is high in cycle E+len+2.
- Minimum turnaround: one IDLE cycle between REPORT and the next COLLECT.
- res_id, res_value and res_ovf hold their values until the next REPORT; res_valid is low outside REPORT.
- The len counter never wraps; it saturates at MAX_LEN.

Test Plan:
- Source 0 sends "begin end" (9 chars, last on 'd'), source 1 idle -> chk_in shows the 9 chars back-to-back, res_valid 11 cycles after the last handshake, res_id=0, res_value=1, res_ovf=0.
- Source 1 sends "begin" -> res_id=1, res_value=0; then "end" -> res_value=0; chk_clear=1 between the two sentences.
- Both sources continuously valid with "begin end" -> results in order id 0,1,0,1; ready never high for both sources in the same cycle.
- Source 0 sends 20 chars ("begin end" + 11 spaces, last on 20th), MAX_LEN=16 -> all 20 accepted, BURST lasts 16 cycles, res_ovf=1, res_value=0.
- Source 0 deasserts valid for 5 cycles mid-sentence "beg|in end" -> chk_clear stays 1 during COLLECT, burst is contiguous, res_value=1.
- Reset driven 0 for one edge during the 4th BURST cycle -> next cycle state IDLE, chk_clear=1, res_valid never pulses, busy=0; a following sentence is granted to source 0.
